// File: rtl/dmem_responder_if.sv
// Load/store request bus between the single-cycle core (master) and the data
// memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        MemWrite;
  logic [1:0]  MemWriteCtr;
  logic [2:0]  MemOutCtr;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rdata;
  logic        done;
  logic        misalign_err;
  logic        stall;

  modport master (
    output req_valid, MemWrite, MemWriteCtr, MemOutCtr, req_addr, req_wdata,
    input  rdata, done, misalign_err, stall
  );

  modport slave (
    input  req_valid, MemWrite, MemWriteCtr, MemOutCtr, req_addr, req_wdata,
    output rdata, done, misalign_err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, WAIT_CYCLES wait states,
// little-endian byte/half/word lanes, sign/zero-extended loads, misalign flag.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic            Clk,
  input logic            Rst,
  dmem_responder_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t             state;
  logic [3:0]         cnt;
  logic               l_write;
  logic [1:0]         l_wctr;
  logic [2:0]         l_octr;
  logic [ADDR_W+1:0]  l_addr;
  logic [31:0]        l_wdata;

  logic [31:0]        mem [2**ADDR_W];

  logic               op_write;
  logic [1:0]         op_wctr;
  logic [2:0]         op_octr;
  logic [ADDR_W+1:0]  op_addr;
  logic [31:0]        op_wdata;
  logic [ADDR_W-1:0]  word_idx;
  logic [31:0]        rd_word;
  logic [3:0]         be;
  logic [31:0]        sdata;
  logic               misaligned;
  logic               fire;
  logic               write_en;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  octr,
                                              input logic [1:0]  lo);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (octr)
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {16'h0000, h};
      3'b011:  return {{24{b[7]}}, b};
      3'b100:  return {24'h000000, b};
      default: return word;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic       wr,
                                         input logic [1:0] wctr,
                                         input logic [2:0] octr,
                                         input logic [1:0] lo);
    if (wr) begin
      case (wctr)
        2'b00:   return lo != 2'b00;
        2'b01:   return lo[0];
        2'b10:   return 1'b0;
        default: return 1'b1;
      endcase
    end
    case (octr)
      3'b001, 3'b010: return lo[0];
      3'b011, 3'b100: return 1'b0;
      default:        return lo != 2'b00;
    endcase
  endfunction

  // With zero wait states the access completes on the accepting edge, so the
  // live request feeds the datapath while idle and the latched copy otherwise.
  always_comb begin
    op_write = l_write;
    op_wctr  = l_wctr;
    op_octr  = l_octr;
    op_addr  = l_addr;
    op_wdata = l_wdata;
    if (state == IDLE) begin
      op_write = bus.MemWrite;
      op_wctr  = bus.MemWriteCtr;
      op_octr  = bus.MemOutCtr;
      op_addr  = bus.req_addr[ADDR_W+1:0];
      op_wdata = bus.req_wdata;
    end
  end

  assign word_idx   = op_addr[ADDR_W+1:2];
  assign rd_word    = mem[word_idx];
  assign misaligned = is_misaligned(op_write, op_wctr, op_octr, op_addr[1:0]);
  assign fire       = (state == IDLE && bus.req_valid && WAIT_CYCLES == 0) ||
                      (state == WAIT && cnt == 4'd1);
  assign write_en   = fire && op_write && !misaligned && !Rst;

  always_comb begin
    be    = 4'b0000;
    sdata = op_wdata;
    case (op_wctr)
      2'b00: be = 4'b1111;
      2'b01: begin
        be    = op_addr[1] ? 4'b1100 : 4'b0011;
        sdata = {2{op_wdata[15:0]}};
      end
      2'b10: begin
        be    = 4'b0001 << op_addr[1:0];
        sdata = {4{op_wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= sdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (state == IDLE && bus.req_valid) begin
      l_write <= bus.MemWrite;
      l_wctr  <= bus.MemWriteCtr;
      l_octr  <= bus.MemOutCtr;
      l_addr  <= bus.req_addr[ADDR_W+1:0];
      l_wdata <= bus.req_wdata;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state            <= IDLE;
      cnt              <= 4'd0;
      bus.done         <= 1'b0;
      bus.misalign_err <= 1'b0;
      bus.rdata        <= 32'h0;
    end else begin
      bus.done         <= fire;
      bus.misalign_err <= fire && misaligned;
      if (fire && !op_write)
        bus.rdata <= misaligned ? 32'h0 : load_extend(rd_word, op_octr, op_addr[1:0]);
      case (state)
        IDLE: if (bus.req_valid) begin
          cnt   <= WAIT_LD;
          state <= (WAIT_CYCLES > 0) ? WAIT : DONE;
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stall = (state == WAIT) ? 1'b1 : (bus.req_valid && !bus.done);
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle core's load/store port; the memory-side end of the controller's MemWrite/MemWriteCtr/MemOutCtr interface.
- Accepts one load or store request at a time and inserts WAIT_CYCLES wait states.
- Performs byte/half/word writes with little-endian lane selection, and sign- or zero-extended reads.
- Drives a stall back to the core until the access completes; flags misaligned accesses.

Parameters:
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between request acceptance and completion; legal range 0..15.

Ports:
- Clk  in  1  clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  a request is presented.
- MemWrite  in  1  1 = store, 0 = load.
- MemWriteCtr  in  2  store size: 00 word, 01 half, 10 byte, 11 illegal.
- MemOutCtr  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu; 101–111 behave as lw.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or half is used for sb/sh.
- rdata  out  32  extended load result.
- done  out  1  one-cycle completion pulse.
- misalign_err  out  1  error flag, valid while done=1.
- stall  out  1  holds the core's PC while a request is outstanding.

Behaviour:
- Reset values: rdata=0, done=0, misalign_err=0, FSM=IDLE, wait counter=0. The memory array is not cleared.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - If req_valid=1 at an edge, latch MemWrite, MemWriteCtr, MemOutCtr, req_addr and req_wdata, and load counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise DONE.
- WAIT: the counter decrements each edge; at the edge where counter==1, go to DONE.
- DONE: done=1 for exactly this cycle, then unconditionally return to IDLE.
- Latency: a request accepted at edge k gives done=1 during the cycle after edge k+WAIT_CYCLES.
- Access timing: the memory write and the rdata register update happen at the edge that enters DONE.
- Hold rules:
  - rdata holds until the next completed load.
  - Stores and errors leave rdata unchanged, except that a misaligned load sets rdata=0.
- Request lifetime:
  - Latched inputs are used throughout the access; a change or drop of req_valid after acceptance has no effect.
  - A request presented during DONE is not accepted; it is accepted on the following IDLE edge.
- stall = req_valid & ~done when the FSM is in IDLE or DONE. stall = 1 while in WAIT.
- Word index = addr[ADDR_W+1:2]. Upper address bits are ignored, so out-of-range addresses wrap.
- Byte lanes (little-endian): addr[1:0]=0 selects bits 7:0, 3 selects bits 31:24. A half at addr[1]=0 uses bits 15:0, addr[1]=1 uses bits 31:16.
- Stores:
  - sb writes only the selected byte lane.
  - sh writes only the selected half.
  - sw writes the full word.
- Loads:
  - lb/lh sign-extend from bit 7 / bit 15 of the selected lane.
  - lbu/lhu zero-extend.
- Misalignment: a half access with addr[0]=1, or a word access with addr[1:0]!=0, or a store with MemWriteCtr=11, gives:
  - no write;
  - misalign_err=1 during DONE;
  - full latency still observed.
- misalign_err is 0 whenever done=0.
- Reset mid-access: the FSM returns to IDLE immediately, any pending write is dropped, and done and stall go low. Memory contents from earlier completed stores persist.

Test Plan:
- sw req_addr=0x10, wdata=0xDEADBEEF, WAIT_CYCLES=2 -> done 3 cycles after acceptance; stall=1 on the acceptance cycle and both WAIT cycles; then lw 0x10 -> rdata=0xDEADBEEF.
- After the word above: sb addr=0x11, wdata=0x000000A5 -> lw 0x10 gives 0xDEADA5EF. lb 0x11 -> 0xFFFFFFA5. lbu 0x11 -> 0x000000A5.
- sh addr=0x22, wdata=0x00008001 -> lh 0x22 gives 0xFFFF8001. lhu 0x22 gives 0x00008001. lw 0x20 upper half = 0x8001.
- lw addr=0x13 -> done with misalign_err=1 and rdata=0. sh addr=0x21 -> misalign_err=1 and the word at 0x20 is unchanged.
- Assert Rst during WAIT of sw 0x30=0x12345678 -> done never pulses; a later lw 0x30 returns the prior contents.
- Back-to-back: req_valid held high for two requests -> second accepted on the edge after DONE; done pulses separated by WAIT_CYCLES+2 cycles. Repeat with WAIT_CYCLES=0 -> done every 2nd cycle.
